mem_stage_ctrl: RTL and testbench

- Parametrised memory-stage controller between the EX/MEM pipeline register and the data-cache request port.
- Accepts one instruction at a time over a valid/ready handshake.
- Posts stores into a SB_DEPTH-entry store buffer that drains to the cache in the background.
- Issues loads, with lane extraction and sign extension, once they are hazard-free. Sequences ecall cache-clean. Returns exactly one response beat per instruction to MEM/WB.

---
 rtl/mem_stage_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// mem_stage_ctrl : memory-stage controller between EX/MEM and the data cache.
//   Buffered stores, hazard-checked loads, ecall cache-clean sequencing.
//   Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage_ctrl #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int SB_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_load,
    input  logic                          req_store,
    input  logic                          req_clean,
    input  logic [1:0]                    req_size,
    input  logic                          req_signed,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [DATA_W-1:0]             resp_data,
    output logic                          resp_fault,
    output logic                          dc_req_valid,
    input  logic                          dc_req_ready,
    output logic                          dc_req_write,
    output logic [ADDR_W-1:0]             dc_req_addr,
    output logic [1:0]                    dc_req_size,
    output logic [DATA_W-1:0]             dc_req_wdata,
    input  logic                          dc_resp_valid,
    input  logic [DATA_W-1:0]             dc_resp_rdata,
    output logic                          dc_clean_req,
    input  logic                          dc_clean_done,
    input  logic                          snoop_stall,
    output logic [$clog2(SB_DEPTH):0]     sb_count
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LD_CHK   = 3'd1;
    localparam logic [2:0] S_LD_ISSUE = 3'd2;
    localparam logic [2:0] S_LD_WAIT  = 3'd3;
    localparam logic [2:0] S_CL_DRAIN = 3'd4;
    localparam logic [2:0] S_CL_WAIT  = 3'd5;
    localparam logic [2:0] S_RESP     = 3'd6;

    logic [2:0]        r_state, w_next;
    logic [ADDR_W-1:0] r_sb_addr  [SB_DEPTH];
    logic [1:0]        r_sb_size  [SB_DEPTH];
    logic [DATA_W-1:0] r_sb_wdata [SB_DEPTH];
    logic [PTR_W-1:0]  r_head, r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_ld_addr;
    logic [1:0]        r_ld_size;
    logic              r_ld_signed;
    logic              r_dc_valid, r_dc_is_ld, r_outstanding, r_out_is_ld;
    logic              r_dc_write;
    logic [ADDR_W-1:0] r_dc_addr;
    logic [1:0]        r_dc_size;
    logic [DATA_W-1:0] r_dc_wdata;
    logic              r_clean_req;
    logic [DATA_W-1:0] r_resp_data;

    logic w_trap, w_is_cl, w_is_ld, w_is_st, w_sb_full, w_accept, w_push, w_pop;
    logic w_port_free, w_issue_ld, w_issue_st, w_dc_acc, w_ld_ack, w_hazard;
    logic [DATA_W-1:0] w_ld_sh, w_ld_mask, w_ld_data;
    logic [IDX_W-1:0]  w_msb;
    logic              w_ld_sign;

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misal;
    logic r_resp_fault;

    // Sizes wider than the data bus are always treated as misaligned.
    always_comb begin
        case (req_size)
            2'd0:    w_misal = 1'b0;
            2'd1:    w_misal = req_addr[0];
            2'd2:    w_misal = |req_addr[1:0];
            default: w_misal = |req_addr[2:0];
        endcase
        if (req_size > 2'(OFF_W))
            w_misal = 1'b1;
    end
    assign w_trap     = w_misal;
    assign resp_fault = r_resp_fault;

    always_ff @(posedge clk) begin
        if (reset)
            r_resp_fault <= 1'b0;
        else if (w_accept)
            r_resp_fault <= w_trap & (w_is_ld | w_is_st);
        else if (r_state == S_RESP && resp_ready)
            r_resp_fault <= 1'b0;
    end
`else
    assign w_trap     = 1'b0;
    assign resp_fault = 1'b0;
`endif

    assign w_is_cl   = req_clean;
    assign w_is_ld   = !req_clean && req_load;
    assign w_is_st   = !req_clean && !req_load && req_store;
    assign w_sb_full = (r_count == CNT_W'(SB_DEPTH));
    assign w_accept  = (r_state == S_IDLE) && req_valid && !(w_is_st && !w_trap && w_sb_full);
    assign w_push    = w_accept && w_is_st && !w_trap;

    assign w_port_free = !r_dc_valid && !r_outstanding;
    assign w_issue_ld  = w_port_free && !snoop_stall && (r_state == S_LD_ISSUE);
    assign w_issue_st  = w_port_free && !snoop_stall && (r_state != S_LD_ISSUE) && (r_count != '0);
    assign w_dc_acc    = r_dc_valid && dc_req_ready;
    assign w_ld_ack    = r_outstanding && r_out_is_ld && dc_resp_valid;
    assign w_pop       = r_outstanding && !r_out_is_ld && dc_resp_valid;

    // Entries stay valid until acked, so an in-flight drain still blocks a load.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((CNT_W'(PTR_W'(PTR_W'(i) - r_head)) < r_count) &&
                (r_sb_addr[i][ADDR_W-1:OFF_W] == r_ld_addr[ADDR_W-1:OFF_W]))
                w_hazard = 1'b1;
        end
    end

    always_comb begin
        case (r_ld_size)
            2'd0:    w_msb = IDX_W'(7);
            2'd1:    w_msb = IDX_W'(15);
            2'd2:    w_msb = IDX_W'(31);
            default: w_msb = IDX_W'(DATA_W - 1);
        endcase
        w_ld_sh   = dc_resp_rdata >> {r_ld_addr[OFF_W-1:0], 3'b000};
        w_ld_mask = ~(({DATA_W{1'b1}} << w_msb) << 1);
        w_ld_sign = r_ld_signed & w_ld_sh[w_msb];
        w_ld_data = (w_ld_sh & w_ld_mask) | ({DATA_W{w_ld_sign}} & ~w_ld_mask);
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_cl)                w_next = S_CL_DRAIN;
                    else if (w_is_ld && !w_trap) w_next = S_LD_CHK;
                    else                         w_next = S_RESP;
                end
            end
            S_LD_CHK:   if (!w_hazard)                   w_next = S_LD_ISSUE;
            S_LD_ISSUE: if (w_dc_acc && r_dc_is_ld)      w_next = S_LD_WAIT;
            S_LD_WAIT:  if (w_ld_ack)                    w_next = S_RESP;
            S_CL_DRAIN: if (r_count == '0 && w_port_free) w_next = S_CL_WAIT;
            S_CL_WAIT:  if (dc_clean_done)               w_next = S_RESP;
            S_RESP:     if (resp_ready)                  w_next = S_IDLE;
            default:                                     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = w_accept && !reset;
        resp_valid = (r_state == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sb_addr[r_tail]  <= req_addr;
            r_sb_size[r_tail]  <= req_size;
            r_sb_wdata[r_tail] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_ld_addr     <= '0;
            r_ld_size     <= '0;
            r_ld_signed   <= 1'b0;
            r_dc_valid    <= 1'b0;
            r_dc_is_ld    <= 1'b0;
            r_outstanding <= 1'b0;
            r_out_is_ld   <= 1'b0;
            r_dc_write    <= 1'b0;
            r_dc_addr     <= '0;
            r_dc_size     <= '0;
            r_dc_wdata    <= '0;
            r_clean_req   <= 1'b0;
            r_resp_data   <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + PTR_W'(1);
            if (w_pop)
                r_head <= r_head + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_accept && w_is_ld) begin
                r_ld_addr   <= req_addr;
                r_ld_size   <= req_size;
                r_ld_signed <= req_signed;
            end

            // A raised request is held until accepted; new ones only on a free port.
            if (w_dc_acc) begin
                r_dc_valid    <= 1'b0;
                r_outstanding <= 1'b1;
                r_out_is_ld   <= r_dc_is_ld;
            end else if (w_issue_ld) begin
                r_dc_valid <= 1'b1;
                r_dc_is_ld <= 1'b1;
                r_dc_write <= 1'b0;
                r_dc_addr  <= r_ld_addr;
                r_dc_size  <= r_ld_size;
                r_dc_wdata <= '0;
            end else if (w_issue_st) begin
                r_dc_valid <= 1'b1;
                r_dc_is_ld <= 1'b0;
                r_dc_write <= 1'b1;
                r_dc_addr  <= r_sb_addr[r_head];
                r_dc_size  <= r_sb_size[r_head];
                r_dc_wdata <= r_sb_wdata[r_head] << {r_sb_addr[r_head][OFF_W-1:0], 3'b000};
            end
            if (r_outstanding && dc_resp_valid)
                r_outstanding <= 1'b0;

            r_clean_req <= (r_state == S_CL_DRAIN) && (w_next == S_CL_WAIT);

            if (w_accept)
                r_resp_data <= '0;
            else if (r_state == S_LD_WAIT && w_ld_ack)
                r_resp_data <= w_ld_data;
            else if (r_state == S_RESP && resp_ready)
                r_resp_data <= '0;
        end
    end

    assign dc_req_valid = r_dc_valid;
    assign dc_req_write = r_dc_write;
    assign dc_req_addr  = r_dc_addr;
    assign dc_req_size  = r_dc_size;
    assign dc_req_wdata = r_dc_wdata;
    assign dc_clean_req = r_clean_req;
    assign resp_data    = r_resp_data;
    assign sb_count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// tb_mem_stage_ctrl : directed self-checking bench for mem_stage_ctrl
//   (ADDR_W=64, DATA_W=64, SB_DEPTH=4) with a byte-lane cache model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic        req_load = 1'b0, req_store = 1'b0, req_clean = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_ready = 1'b1;
    logic [63:0] resp_data;
    logic        resp_fault;
    logic        dc_req_valid, dc_req_ready = 1'b0, dc_req_write;
    logic [63:0] dc_req_addr, dc_req_wdata;
    logic [1:0]  dc_req_size;
    logic        dc_resp_valid = 1'b0;
    logic [63:0] dc_resp_rdata = '0;
    logic        dc_clean_req, dc_clean_done = 1'b0;
    logic        snoop_stall = 1'b0;
    logic [2:0]  sb_count;

    int total = 0;
    int bad   = 0;

    // Cache model state
    logic [63:0] mem [logic [63:0]];
    bit          log_w [$];
    logic [63:0] log_a [$];
    logic [63:0] log_d [$];
    int          n_ack = 0, n_clean = 0, n_dcv = 0;
    bit          resp_hold = 1'b0;

    mem_stage_ctrl #(.ADDR_W(64), .DATA_W(64), .SB_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_clean(req_clean),
        .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_fault(resp_fault),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_write(dc_req_write), .dc_req_addr(dc_req_addr),
        .dc_req_size(dc_req_size), .dc_req_wdata(dc_req_wdata),
        .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
        .dc_clean_req(dc_clean_req), .dc_clean_done(dc_clean_done),
        .snoop_stall(snoop_stall), .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    // One-cycle-latency cache: samples handshakes mid-cycle, answers after the edge.
    initial begin : cache_model
        bit          acc, a_w;
        logic [63:0] a_addr, a_wd, line_v;
        logic [1:0]  a_size;
        forever begin
            @(negedge clk);
            acc    = dc_req_valid && dc_req_ready && !reset;
            a_w    = dc_req_write;
            a_addr = dc_req_addr;
            a_size = dc_req_size;
            a_wd   = dc_req_wdata;
            if (dc_clean_req) n_clean++;
            if (dc_req_valid) n_dcv++;
            @(posedge clk);
            #1;
            dc_resp_valid = 1'b0;
            if (acc) begin
                log_w.push_back(a_w);
                log_a.push_back(a_addr);
                log_d.push_back(a_wd);
                if (!resp_hold) begin
                    line_v = mem.exists(a_addr >> 3) ? mem[a_addr >> 3] : 64'h0;
                    if (a_w) begin
                        for (int b = 0; b < 8; b++)
                            if (b >= int'(a_addr[2:0]) && b < int'(a_addr[2:0]) + (1 << a_size))
                                line_v[8*b +: 8] = a_wd[8*b +: 8];
                        mem[a_addr >> 3] = line_v;
                        n_ack++;
                    end else begin
                        dc_resp_rdata = line_v;
                    end
                    dc_resp_valid = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic ld, input logic st, input logic cl, input logic [1:0] sz,
                          input logic sg, input logic [63:0] a, input logic [63:0] wd,
                          output bit ok);
        req_load = ld; req_store = st; req_clean = cl; req_size = sz;
        req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; req_clean = 1'b0;
    endtask

    task automatic wait_resp(output bit ok, output logic [63:0] d, output logic f);
        ok = 1'b0; d = '0; f = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                ok = 1'b1; d = resp_data; f = resp_fault;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        bit ok; logic [63:0] d; logic f;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL rst_dc_req_valid: got %b want 0", dc_req_valid); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        total++; if (dc_clean_req !== 1'b0) begin bad++; $display("FAIL rst_clean_req: got %b want 0", dc_clean_req); end
        total++; if (sb_count !== 3'd0) begin bad++; $display("FAIL rst_sb_count: got %0d want 0", sb_count); end
        total++; if (resp_data !== 64'h0 || resp_fault !== 1'b0) begin bad++; $display("FAIL rst_resp: got %h/%b want 0/0", resp_data, resp_fault); end
        // Instruction with no memory op still gets exactly one zero response.
        do_req(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, ok);
        wait_resp(ok, d, f);
        total++; if (!ok || d !== 64'h0) begin bad++; $display("FAIL nop_resp: got ok=%b data=%h want ok=1 data=0", ok, d); end
    endtask

    task automatic test_sign();
        bit ok; logic [63:0] d; logic f;
        dc_req_ready = 1'b1;
        mem[64'h20] = 64'h80FF_0000_0000_0000;
        do_req(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 64'h107, 64'h0, ok);
        wait_resp(ok, d, f);
        total++; if (!ok || d !== 64'hFFFF_FFFF_FFFF_FF80) begin bad++; $display("FAIL ld_b_signed: got %h want ffffffffffffff80", d); end
        do_req(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h107, 64'h0, ok);
        wait_resp(ok, d, f);
        total++; if (!ok || d !== 64'h80) begin bad++; $display("FAIL ld_bu: got %h want 80", d); end
        do_req(1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 64'h104, 64'h0, ok);
        wait_resp(ok, d, f);
        total++; if (!ok || d !== 64'hFFFF_FFFF_80FF_0000) begin bad++; $display("FAIL ld_w_signed: got %h want ffffffff80ff0000", d); end
        total++; if (log_w[$] !== 1'b0 || log_a[$] !== 64'h104) begin bad++; $display("FAIL ld_req_fields: got w=%b a=%h want w=0 a=104", log_w[$], log_a[$]); end
    endtask

    task automatic test_store_load();
        bit ok; logic [63:0] d; logic f; int n0, n1;
        dc_req_ready = 1'b0;
        n0 = log_w.size();
        do_req(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 64'h100, 64'h1122_3344_5566_7788, ok);
        wait_resp(ok, d, f);
        total++; if (!ok || d !== 64'h0) begin bad++; $display("FAIL st_resp: got ok=%b data=%h want 1/0", ok, d); end
        do_req(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h103, 64'h0, ok);
        repeat (4) tick();
        total++; if (dc_req_valid !== 1'b1 || dc_req_write !== 1'b1 || sb_count !== 3'd1)
            begin bad++; $display("FAIL hazard_hold: got v=%b w=%b cnt=%0d want 1/1/1", dc_req_valid, dc_req_write, sb_count); end
        dc_req_ready = 1'b1;
        wait_resp(ok, d, f);
        total++; if (!ok || d !== 64'h55) begin bad++; $display("FAIL st_then_ld: got %h want 55", d); end
        total++; if (log_w.size() != n0 + 2 || log_w[n0] !== 1'b1 || log_w[n0+1] !== 1'b0 || log_a[n0+1] !== 64'h103)
            begin bad++; $display("FAIL st_ld_order: got n=%0d want %0d store-then-load", log_w.size() - n0, 2); end
        n1 = log_w.size();
        do_req(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 64'h10A, 64'hBEEF, ok);
        wait_resp(ok, d, f);
        do_req(1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 64'h10A, 64'h0, ok);
        wait_resp(ok, d, f);
        total++; if (!ok || d !== 64'hFFFF_FFFF_FFFF_BEEF) begin bad++; $display("FAIL ld_h_signed: got %h want ffffffffffffbeef", d); end
        total++; if (log_d[n1] !== 64'h0000_0000_BEEF_0000) begin bad++; $display("FAIL st_lane: got %h want 00000000beef0000", log_d[n1]); end
    endtask

    task automatic test_misalign();
        bit ok; logic [63:0] d; logic f; int v0;
        dc_req_ready = 1'b1;
        v0 = n_dcv;
        do_req(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 64'h102, 64'h0, ok);
        wait_resp(ok, d, f);
`ifdef MEM_MISALIGN_TRAP_EN
        total++; if (!ok || f !== 1'b1 || d !== 64'h0) begin bad++; $display("FAIL misal_trap: got f=%b d=%h want 1/0", f, d); end
        total++; if (n_dcv != v0) begin bad++; $display("FAIL misal_no_req: got %0d req cycles want 0", n_dcv - v0); end
`else
        total++; if (!ok || f !== 1'b0 || d !== 64'h3344_5566) begin bad++; $display("FAIL misal_pass: got f=%b d=%h want 0/33445566", f, d); end
        total++; if (n_dcv == v0) begin bad++; $display("FAIL misal_issued: got 0 req cycles want >0"); end
`endif
    endtask

    task automatic test_sb_full();
        bit ok, all_ok; logic [63:0] d; logic f; int n0, stuck, errs; logic [2:0] cnt_at;
        dc_req_ready = 1'b0;
        n0 = log_w.size();
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 64'h200 + 64'(8*i), 64'hA0 + 64'(i), ok);
            all_ok &= ok;
            wait_resp(ok, d, f);
            all_ok &= ok;
        end
        total++; if (!all_ok || sb_count !== 3'd4) begin bad++; $display("FAIL sb_fill: got ok=%b cnt=%0d want 1/4", all_ok, sb_count); end
        req_store = 1'b1; req_size = 2'd3; req_addr = 64'h220; req_wdata = 64'hA4; req_valid = 1'b1;
        stuck = 0;
        repeat (5) begin @(negedge clk); if (req_ready) stuck++; end
        total++; if (stuck != 0) begin bad++; $display("FAIL sb_full_ready: got %0d ready cycles want 0", stuck); end
        @(posedge clk); #1;
        dc_req_ready = 1'b1;
        ok = 1'b0; cnt_at = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; cnt_at = sb_count; break; end
        end
        tick();
        req_valid = 1'b0; req_store = 1'b0;
        total++; if (!ok || cnt_at !== 3'd3 || n_ack == 0) begin bad++; $display("FAIL sb_after_ack: got ok=%b cnt=%0d want 1/3", ok, cnt_at); end
        wait_resp(ok, d, f);
        for (int i = 5; i < 10; i++) begin
            do_req(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 64'h200 + 64'(8*i), 64'hA0 + 64'(i), ok);
            wait_resp(ok, d, f);
        end
        for (int i = 0; i < 200 && sb_count != 3'd0; i++) tick();
        total++; if (sb_count !== 3'd0) begin bad++; $display("FAIL sb_drain: got %0d want 0", sb_count); end
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            if (n0 + i >= log_w.size()) errs++;
            else if (log_w[n0+i] !== 1'b1 || log_a[n0+i] !== 64'h200 + 64'(8*i) || mem[(64'h200 + 64'(8*i)) >> 3] !== 64'hA0 + 64'(i)) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL sb_wrap_order: got %0d wrong entries want 0", errs); end
    endtask

    task automatic test_clean();
        bit ok; logic [63:0] d; logic f; int a0, c0; logic [2:0] cnt_at;
        dc_req_ready = 1'b0;
        a0 = n_ack; c0 = n_clean;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 64'h300 + 64'(8*i), 64'(i), ok);
            wait_resp(ok, d, f);
        end
        total++; if (sb_count !== 3'd3) begin bad++; $display("FAIL cl_prefill: got %0d want 3", sb_count); end
        do_req(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 64'h0, 64'h0, ok);
        repeat (4) tick();
        total++; if (n_clean != c0 || resp_valid !== 1'b0) begin bad++; $display("FAIL cl_early: got pulses=%0d resp=%b want 0/0", n_clean - c0, resp_valid); end
        dc_req_ready = 1'b1;
        ok = 1'b0; cnt_at = '1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dc_clean_req) begin ok = 1'b1; cnt_at = sb_count; break; end
        end
        total++; if (!ok || cnt_at !== 3'd0 || n_ack - a0 != 3) begin bad++; $display("FAIL cl_after_acks: got ok=%b cnt=%0d acks=%0d want 1/0/3", ok, cnt_at, n_ack - a0); end
        repeat (3) tick();
        total++; if (n_clean - c0 != 1 || resp_valid !== 1'b0) begin bad++; $display("FAIL cl_pulse_once: got pulses=%0d resp=%b want 1/0", n_clean - c0, resp_valid); end
        dc_clean_done = 1'b1;
        tick();
        dc_clean_done = 1'b0;
        wait_resp(ok, d, f);
        total++; if (!ok || d !== 64'h0) begin bad++; $display("FAIL cl_resp: got ok=%b d=%h want 1/0", ok, d); end
    endtask

    task automatic test_snoop();
        bit ok; logic [63:0] d; logic f; int v0, drop;
        dc_req_ready = 1'b1;
        snoop_stall = 1'b1;
        v0 = n_dcv;
        do_req(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 64'h400, 64'h1, ok);
        wait_resp(ok, d, f);
        do_req(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 64'h408, 64'h2, ok);
        wait_resp(ok, d, f);
        repeat (5) tick();
        total++; if (n_dcv != v0 || sb_count !== 3'd2) begin bad++; $display("FAIL snoop_block: got reqs=%0d cnt=%0d want 0/2", n_dcv - v0, sb_count); end
        snoop_stall = 1'b0;
        @(negedge clk);
        total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL snoop_same_cycle: got %b want 0", dc_req_valid); end
        @(negedge clk);
        total++; if (dc_req_valid !== 1'b1) begin bad++; $display("FAIL snoop_resume: got %b want 1", dc_req_valid); end
        tick();
        for (int i = 0; i < 100 && sb_count != 3'd0; i++) tick();
        dc_req_ready = 1'b0;
        do_req(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 64'h410, 64'h3, ok);
        wait_resp(ok, d, f);
        snoop_stall = 1'b1;
        drop = 0;
        repeat (3) begin @(negedge clk); if (!dc_req_valid) drop++; end
        tick();
        total++; if (drop != 0) begin bad++; $display("FAIL snoop_hold_raised: got %0d low cycles want 0", drop); end
        dc_req_ready = 1'b1;
        for (int i = 0; i < 50 && sb_count != 3'd0; i++) tick();
        total++; if (sb_count !== 3'd0) begin bad++; $display("FAIL snoop_raised_drains: got %0d want 0", sb_count); end
        snoop_stall = 1'b0;
    endtask

    task automatic test_reset_ldwait();
        bit ok; logic [63:0] d; logic f; int n0;
        dc_req_ready = 1'b1;
        snoop_stall = 1'b1;
        do_req(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 64'h500, 64'h5, ok);
        wait_resp(ok, d, f);
        do_req(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 64'h600, 64'h0, ok);
        repeat (3) tick();
        resp_hold = 1'b1;
        n0 = log_w.size();
        snoop_stall = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (log_w.size() > n0) begin ok = 1'b1; break; end
        end
        total++; if (!ok || log_w[n0] !== 1'b0 || log_a[n0] !== 64'h600) begin bad++; $display("FAIL ld_beats_drain: got ok=%b first-write=%b want 1/0", ok, ok ? log_w[n0] : 1'b1); end
        tick();
        reset = 1'b1;
        tick();
        total++; if (dc_req_valid !== 1'b0 || resp_valid !== 1'b0 || dc_clean_req !== 1'b0 || req_ready !== 1'b0)
            begin bad++; $display("FAIL rst_ldwait_ctrl: got %b%b%b%b want 0000", dc_req_valid, resp_valid, dc_clean_req, req_ready); end
        total++; if (sb_count !== 3'd0 || resp_data !== 64'h0 || resp_fault !== 1'b0 || dc_req_write !== 1'b0 || dc_req_addr !== 64'h0)
            begin bad++; $display("FAIL rst_ldwait_data: got cnt=%0d d=%h f=%b want 0/0/0", sb_count, resp_data, resp_fault); end
        reset = 1'b0;
        resp_hold = 1'b0;
        tick();
    endtask

    initial begin : main
        test_reset();
        test_sign();
        test_store_load();
        test_misalign();
        test_sb_full();
        test_clean();
        test_snoop();
        test_reset_ldwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
